scmp_bus_seq: RTL and testbench



---
 rtl/scmp_bus_seq.sv | 183 ++++++++++++++++++
 tb/tb_scmp_bus_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_seq.sv
// scmp_bus_seq - external bus cycle sequencer and multiprocessor bus arbiter
// for the SC/MP core.
//
// The microcode sequencer holds one cycle request. This block then does the
// following:
//   - wins the shared bus through the BREQ/ENIN/ENOUT daisy chain;
//   - runs the NADS -> NRDS/NWDS strobe sequence, stretched by NHOLD;
//   - returns read data;
//   - pulses cyc_done.
// The microcode is stalled for as long as a request is outstanding.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no cycle in progress; waiting for cyc_req
// ARB   | request latched; waiting for enin=1 and a quiet BREQ line
// ADDR  | bus owned; NADS low; address and flags on the bus
// DATA  | NRDS or NWDS low; minimum strobe time, then stretched by NHOLD
// REL   | strobes high and bus released; cyc_done high for one cycle
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cyc_req/rd/wr/flg/addr/wdata request from the microcode sequencer
//   stall, cyc_done, rdata       status and read data returned to microcode
//   cyc_err                      sticky protocol/timeout error flag
//   breq_o, breq_i, enin, enout  multiprocessor arbitration chain
//   nads, nrds, nwds, nhold      bus strobes and wait request (active low)
//   a_o, d_o, d_oe, d_i          address and data bus
module scmp_bus_seq #(
  parameter int ADS_CYC  = 1,
  parameter int STB_CYC  = 2,
  parameter int HOLD_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_req,
  input  logic        cyc_rd,
  input  logic        cyc_wr,
  input  logic [3:0]  cyc_flg,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  output logic        stall,
  output logic        cyc_done,
  output logic [7:0]  rdata,
  output logic        cyc_err,
  output logic        breq_o,
  input  logic        breq_i,
  input  logic        enin,
  output logic        enout,
  output logic        nads,
  output logic        nrds,
  output logic        nwds,
  input  logic        nhold,
  output logic [15:0] a_o,
  output logic [7:0]  d_o,
  output logic        d_oe,
  input  logic [7:0]  d_i
);

  typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, REL} state_t;

  localparam int              HW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [2:0]      ADS_LD  = 3'(ADS_CYC - 1);
  localparam logic [2:0]      STB_LD  = 3'(STB_CYC - 1);
  localparam logic [HW-1:0]   HOLD_LD = HW'(HOLD_MAX);
  localparam bit              HOLD_EN = (HOLD_MAX != 0);

  state_t         state, state_nxt;
  logic [2:0]     tmr;          // ADDR / minimum-strobe down-counter
  logic [HW-1:0]  hold_tmr;     // remaining NHOLD extension budget
  logic           rd_l, wr_l;
  logic [3:0]     flg_l;
  logic [15:0]    addr_l;
  logic [7:0]     wdata_l;

  logic           stb_done, strobe_end, hold_abort, arb_win;

  assign arb_win    = enin & ~breq_i;
  assign stb_done   = (tmr == 3'd0);
  assign strobe_end = (state == DATA) & stb_done & nhold;
  // Timeout only fires while NHOLD is still low; a release on the same edge wins.
  assign hold_abort = HOLD_EN & (state == DATA) & stb_done & ~nhold & (hold_tmr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      hold_tmr <= '0;
      rd_l     <= 1'b0;
      wr_l     <= 1'b0;
      flg_l    <= '0;
      addr_l   <= '0;
      wdata_l  <= '0;
      a_o      <= '0;
      rdata    <= '0;
      cyc_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cyc_req) begin
            // Both rd and wr set degrades to a read.
            rd_l    <= cyc_rd;
            wr_l    <= cyc_wr & ~cyc_rd;
            flg_l   <= cyc_flg;
            addr_l  <= cyc_addr;
            wdata_l <= cyc_wdata;
            if (cyc_rd == cyc_wr) cyc_err <= 1'b1;
          end
        end
        ARB: begin
          if (arb_win) begin
            a_o <= addr_l;
            tmr <= ADS_LD;
          end
        end
        ADDR: begin
          if (stb_done) begin
            tmr      <= STB_LD;
            hold_tmr <= HOLD_LD;
          end else begin
            tmr <= tmr - 3'd1;
          end
        end
        DATA: begin
          if (!stb_done) begin
            tmr <= tmr - 3'd1;
          end else if (nhold) begin
            if (rd_l) rdata <= d_i;
          end else if (hold_abort) begin
            rdata   <= 8'hFF;
            cyc_err <= 1'b1;
          end else if (hold_tmr != '0) begin
            hold_tmr <= hold_tmr - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cyc_req) state_nxt = (cyc_rd | cyc_wr) ? ARB : REL;
      ARB:  if (arb_win) state_nxt = ADDR;
      ADDR: if (stb_done) state_nxt = DATA;
      DATA: if (strobe_end | hold_abort) state_nxt = REL;
      REL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nads     = 1'b1;
    nrds     = 1'b1;
    nwds     = 1'b1;
    breq_o   = 1'b0;
    d_oe     = 1'b0;
    d_o      = 8'h00;
    cyc_done = 1'b0;
    case (state)
      ADDR: begin
        nads   = 1'b0;
        breq_o = 1'b1;
        d_oe   = 1'b1;
        d_o    = {4'b0000, flg_l};
      end
      DATA: begin
        breq_o = 1'b1;
        nrds   = ~rd_l;
        nwds   = ~wr_l;
        d_oe   = wr_l;
        if (wr_l) d_o = wdata_l;
      end
      REL:  cyc_done = 1'b1;
      default: ;
    endcase
  end

  assign stall = cyc_req & ~cyc_done;
  assign enout = enin & ~breq_o & ~(state == ARB);

endmodule

// File: tb/tb_scmp_bus_seq.sv
// tb_scmp_bus_seq - self-checking bench for scmp_bus_seq.
// Each bus cycle pushes its expected {rdata, cyc_err} onto a scoreboard.
// The entry is popped when cyc_done appears. Strobe widths, latency and bus
// contents are measured on the falling edge.
module tb_scmp_bus_seq;

  localparam int ADS  = 1;
  localparam int STB  = 2;
  localparam int HMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_req, cyc_rd, cyc_wr;
  logic [3:0]  cyc_flg;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        stall, cyc_done, cyc_err;
  logic [7:0]  rdata;
  logic        breq_o, breq_i, enin, enout;
  logic        nads, nrds, nwds, nhold;
  logic [15:0] a_o;
  logic [7:0]  d_o, d_i;
  logic        d_oe;

  always #5 clk = ~clk;

  scmp_bus_seq #(.ADS_CYC(ADS), .STB_CYC(STB), .HOLD_MAX(HMAX)) dut (
    .clk(clk), .rst(rst),
    .cyc_req(cyc_req), .cyc_rd(cyc_rd), .cyc_wr(cyc_wr), .cyc_flg(cyc_flg),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .stall(stall), .cyc_done(cyc_done), .rdata(rdata), .cyc_err(cyc_err),
    .breq_o(breq_o), .breq_i(breq_i), .enin(enin), .enout(enout),
    .nads(nads), .nrds(nrds), .nwds(nwds), .nhold(nhold),
    .a_o(a_o), .d_o(d_o), .d_oe(d_oe), .d_i(d_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_model;
  logic       err_model;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cyc_req = 1'b0; breq_i = 1'b0; enin = 1'b1; nhold = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_model  = 8'h00;
    err_model = 1'b0;
  endtask

  // hold_lo: strobe cycles with NHOLD low after the minimum strobe time.
  // busy:    falling edge on which a competing BREQ drops (0 = bus free).
  task automatic bus_cycle(input string tag, input logic rd, input logic wr,
                           input logic [3:0] flg, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] din,
                           input int hold_lo, input int busy);
    int   n, done_at, nads_n, stb_n, exp_stb, exp_done, exp_nads;
    bit   addr_ok, data_ok, arb_ok, saw_rd, saw_wr, abort, none;
    exp_t e;
    none     = !rd && !wr;
    abort    = !none && (hold_lo > HMAX);
    exp_stb  = none ? 0 : (abort ? STB + HMAX : STB + hold_lo);
    exp_nads = none ? 0 : ADS;
    exp_done = none ? 2 : 3 + ADS + exp_stb + ((busy > 2) ? busy - 2 : 0);
    rd_model  = abort ? 8'hFF : ((rd && !none) ? din : rd_model);
    err_model = err_model | (rd == wr) | abort;
    sb.push_back('{rd_model, err_model});

    @(posedge clk); #1;
    cyc_rd = rd; cyc_wr = wr; cyc_flg = flg; cyc_addr = addr; cyc_wdata = wd;
    d_i = din; nhold = 1'b1; enin = 1'b1; breq_i = (busy > 0);
    cyc_req = 1'b1;

    n = 0; done_at = -1; nads_n = 0; stb_n = 0;
    addr_ok = 1; data_ok = 1; arb_ok = 1; saw_rd = 0; saw_wr = 0;
    while (done_at < 0 && n < 300) begin
      @(negedge clk); n++;
      if (busy > 0 && n >= 2 && n <= busy && (enout !== 1'b0 || nads !== 1'b1)) arb_ok = 0;
      if (busy > 0 && n == busy) breq_i = 1'b0;
      if (nads === 1'b0) begin
        nads_n++;
        if (a_o !== addr || d_o !== {4'b0000, flg} || d_oe !== 1'b1) addr_ok = 0;
      end
      if (nrds === 1'b0 || nwds === 1'b0) begin
        stb_n++;
        if (nrds === 1'b0) begin
          saw_rd = 1;
          if (nwds !== 1'b1 || d_oe !== 1'b0) data_ok = 0;
        end
        if (nwds === 1'b0) begin
          saw_wr = 1;
          if (nrds !== 1'b1 || d_oe !== 1'b1 || d_o !== wd) data_ok = 0;
        end
        nhold = !(stb_n >= STB && stb_n < STB + hold_lo);
      end else begin
        nhold = 1'b1;
      end
      if (cyc_done === 1'b1) done_at = n;
    end

    chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    chk({tag, "_nads_len"},   32'(nads_n),  32'(exp_nads));
    chk({tag, "_stb_len"},    32'(stb_n),   32'(exp_stb));
    chk({tag, "_addr_phase"}, 32'(addr_ok), 1);
    chk({tag, "_data_phase"}, 32'(data_ok), 1);
    chk({tag, "_rd_strobe"},  32'(saw_rd),  32'(rd && !none));
    chk({tag, "_wr_strobe"},  32'(saw_wr),  32'(wr && !rd));
    if (busy > 0) chk({tag, "_arb_wait"}, 32'(arb_ok), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_entry"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"},   32'(rdata),   32'(e.rd));
      chk({tag, "_cyc_err"}, 32'(cyc_err), 32'(e.err));
    end

    @(posedge clk); #1 cyc_req = 1'b0; nhold = 1'b1;
    @(negedge clk);
    chk({tag, "_breq_rel"}, 32'(breq_o),   0);
    chk({tag, "_done_one"}, 32'(cyc_done), 0);
    chk({tag, "_stall_rel"}, 32'(stall),   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok;
    logic r;
    rst = 1'b1; cyc_req = 1'b0; cyc_rd = 1'b0; cyc_wr = 1'b0; cyc_flg = 4'h0;
    cyc_addr = 16'h0; cyc_wdata = 8'h0; breq_i = 1'b0; enin = 1'b1;
    nhold = 1'b1; d_i = 8'h00;
    do_reset();

    @(negedge clk);
    chk("rst_nads",  32'(nads),     1);
    chk("rst_nrds",  32'(nrds),     1);
    chk("rst_nwds",  32'(nwds),     1);
    chk("rst_breq",  32'(breq_o),   0);
    chk("rst_d_oe",  32'(d_oe),     0);
    chk("rst_a_o",   32'(a_o),      0);
    chk("rst_d_o",   32'(d_o),      0);
    chk("rst_rdata", 32'(rdata),    0);
    chk("rst_done",  32'(cyc_done), 0);
    chk("rst_err",   32'(cyc_err),  0);
    chk("rst_stall", 32'(stall),    0);
    chk("rst_enout", 32'(enout),    1);

    bus_cycle("rd_basic", 1'b1, 1'b0, 4'hA, 16'h1234, 8'h00, 8'h5A, 0, 0);
    bus_cycle("wr_hold3", 1'b0, 1'b1, 4'h3, 16'h8001, 8'hC3, 8'h00, 3, 0);
    bus_cycle("rd_arb",   1'b1, 1'b0, 4'h5, 16'hBEEF, 8'h00, 8'h11, 0, 10);
    bus_cycle("rd_tmo",   1'b1, 1'b0, 4'h1, 16'h0F0F, 8'h00, 8'h22, 100, 0);
    bus_cycle("wr_stky",  1'b0, 1'b1, 4'h2, 16'h0010, 8'h77, 8'h00, 0, 0);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      r = 1'(($urandom_range(0, 1)));
      bus_cycle($sformatf("rnd%0d", i), r, ~r, 4'($urandom_range(0, 15)),
                16'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 0);
    end

    // enin low: the request can never win the bus
    do_reset();
    @(posedge clk); #1 enin = 1'b0; cyc_rd = 1'b1; cyc_wr = 1'b0; cyc_req = 1'b1;
    ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (enout !== 1'b0 || stall !== 1'b1 || nads !== 1'b1 || breq_o !== 1'b0) ok = 0;
    end
    chk("enin0_blocked", 32'(ok), 1);
    chk("enin0_stall", 32'(stall), 1);
    do_reset();

    // reset taken while the read strobe is low
    @(posedge clk); #1 cyc_rd = 1'b1; cyc_wr = 1'b0; cyc_addr = 16'h4444;
    d_i = 8'h99; nhold = 1'b0; cyc_req = 1'b1;
    n = 0;
    while (nrds !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_reach", 32'(nrds), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_nrds",  32'(nrds),     1);
    chk("rst_mid_breq",  32'(breq_o),   0);
    chk("rst_mid_done",  32'(cyc_done), 0);
    chk("rst_mid_enout", 32'(enout),    1);
    cyc_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0; nhold = 1'b1;
    rd_model = 8'h00; err_model = 1'b0;
    ok = 1;
    repeat (5) begin @(negedge clk); if (cyc_done !== 1'b0) ok = 0; end
    chk("rst_mid_nodone", 32'(ok), 1);
    chk("rst_mid_rdata", 32'(rdata), 0);

    bus_cycle("rdwr_both", 1'b1, 1'b1, 4'h6, 16'h2222, 8'hAA, 8'h3C, 0, 0);
    do_reset();
    bus_cycle("neither",   1'b0, 1'b0, 4'h0, 16'h3333, 8'h00, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
